// File: rtl/vip_pkg.sv
// ============================================================================
// Module   : vip_pkg
// Purpose  : Shared types and constants for the Avalon-ST video input stage.
//            Packet type codes, decoder state encoding, control field record
//            and a saturating counter helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vip_pkg;

   localparam logic [3:0] PKT_VIDEO = 4'h0;
   localparam logic [3:0] PKT_CTRL  = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CTRL  = 2'd1,
      S_VIDEO = 2'd2,
      S_OTHER = 2'd3
   } vip_state_e;

   typedef struct packed {
      logic [15:0] width;
      logic [15:0] height;
      logic [3:0]  interlace;
   } vip_ctrl_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/avst_skid_buffer.sv
// ============================================================================
// Module   : avst_skid_buffer
// Purpose  : Generic 2-entry ready/valid slice. Full throughput, one cycle
//            latency from input acceptance to output valid, registered ready.
// Ports    : clk_i, rst_n_i        clock, async active-low reset
//            in_valid_i/in_ready_o/in_data_i     sink side
//            out_valid_o/out_ready_i/out_data_o  source side
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module avst_skid_buffer
   import vip_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o
);

   logic [DW-1:0] ent0_q, ent0_d;
   logic [DW-1:0] ent1_q, ent1_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic [1:0]    count_q, count_d;
   // Holds ready low while reset is asserted and until the first clock after.
   logic          live_q, live_d;

   logic in_acc;
   logic out_acc;

   assign in_ready_o  = live_q & (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = rd_ptr_q ? ent1_q : ent0_q;

   assign in_acc  = in_valid_i & in_ready_o;
   assign out_acc = out_valid_o & out_ready_i;

   always_comb begin
      ent0_d   = ent0_q;
      ent1_d   = ent1_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      live_d   = 1'b1;
      count_d  = count_q + {1'b0, in_acc} - {1'b0, out_acc};
      if (in_acc) begin
         if (wr_ptr_q) ent1_d = in_data_i;
         else          ent0_d = in_data_i;
         wr_ptr_d = ~wr_ptr_q;
      end
      if (out_acc) begin
         rd_ptr_d = ~rd_ptr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ent0_q   <= '0;
         ent1_q   <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         live_q   <= 1'b0;
      end else begin
         ent0_q   <= ent0_d;
         ent1_q   <= ent1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         live_q   <= live_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vip_ctrl_decoder.sv
// ============================================================================
// Module   : vip_ctrl_decoder
// Purpose  : Avalon-ST video input stage. Forwards every beat through a skid
//            buffer, decodes control packets into width/height/interlace,
//            tags video pixels with end-of-line / start-of-frame sideband and
//            reports frames whose pixel count differs from width*height.
// Ports    : clk_i, rst_n_i                    clock, async active-low reset
//            avst_din_*                        Avalon-ST sink
//            avst_dout_*, dout_eol_o, dout_sof_o  Avalon-ST source + sideband
//            width_o, height_o, interlace_o    active control fields
//            ctrl_update_o, ctrl_err_o         control commit / reject pulses
//            frame_done_o, frame_short_o, frame_long_o  frame status pulse
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vip_ctrl_decoder
   import vip_pkg::*;
#(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   parameter int DEFAULT_WIDTH    = 20,
   parameter int DEFAULT_HEIGHT   = 20
) (
   input  logic                                      clk_i,
   input  logic                                      rst_n_i,
   output logic                                      avst_din_ready_o,
   input  logic                                      avst_din_valid_i,
   input  logic                                      avst_din_sop_i,
   input  logic                                      avst_din_eop_i,
   input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] avst_din_data_i,
   input  logic                                      avst_dout_ready_i,
   output logic                                      avst_dout_valid_o,
   output logic                                      avst_dout_sop_o,
   output logic                                      avst_dout_eop_o,
   output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] avst_dout_data_o,
   output logic                                      dout_eol_o,
   output logic                                      dout_sof_o,
   output logic [15:0]                               width_o,
   output logic [15:0]                               height_o,
   output logic [3:0]                                interlace_o,
   output logic                                      ctrl_update_o,
   output logic                                      ctrl_err_o,
   output logic                                      frame_done_o,
   output logic                                      frame_short_o,
   output logic                                      frame_long_o
);

   localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
   localparam int BW = DW + 4;

   // ------------------------------------------------------------------
   // Low nibble of symbols 0..2 of the incoming beat
   // ------------------------------------------------------------------
   logic [3:0] nib0, nib1, nib2;

   generate
      if (SYMBOLS_PER_BEAT >= 3 && BITS_PER_SYMBOL >= 4) begin : g_nib
         assign nib0 = avst_din_data_i[3:0];
         assign nib1 = avst_din_data_i[BITS_PER_SYMBOL+3:BITS_PER_SYMBOL];
         assign nib2 = avst_din_data_i[2*BITS_PER_SYMBOL+3:2*BITS_PER_SYMBOL];
      end else begin : g_no_nib
         // Control decoding needs three symbols; narrower beats never commit.
         assign nib0 = 4'h0;
         assign nib1 = 4'h0;
         assign nib2 = 4'h0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   vip_state_e  state_q, state_d;
   logic [1:0]  k_q, k_d;
   vip_ctrl_t   shadow_q, shadow_d;
   vip_ctrl_t   fields_q, fields_d;
   logic [15:0] x_q, x_d;
   logic [31:0] pix_cnt_q, pix_cnt_d;
   logic        ctrl_update_q, ctrl_update_d;
   logic        ctrl_err_q, ctrl_err_d;
   logic        frame_done_q, frame_done_d;
   logic        frame_short_q, frame_short_d;
   logic        frame_long_q, frame_long_d;

   logic        acc, acc_sop, acc_beat, acc_eop;
   logic [3:0]  pkt_type;
   logic [31:0] frame_size;
   logic        pix_eol, pix_sof;

   assign acc        = avst_din_valid_i & avst_din_ready_o;
   assign acc_sop    = acc & avst_din_sop_i;
   assign acc_beat   = acc & ~avst_din_sop_i;
   assign acc_eop    = acc & avst_din_eop_i;
   assign pkt_type   = avst_din_data_i[3:0];
   assign frame_size = 32'(fields_q.width) * 32'(fields_q.height);

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      shadow_d      = shadow_q;
      fields_d      = fields_q;
      x_d           = x_q;
      pix_cnt_d     = pix_cnt_q;
      ctrl_update_d = 1'b0;
      ctrl_err_d    = 1'b0;
      frame_done_d  = 1'b0;
      frame_short_d = 1'b0;
      frame_long_d  = 1'b0;
      pix_eol       = 1'b0;
      pix_sof       = 1'b0;

      if (acc_sop) begin
         // A new sop closes whatever packet was still open.
         if (state_q == S_VIDEO) begin
            frame_done_d  = 1'b1;
            frame_short_d = 1'b1;
         end
         if (state_q == S_CTRL) begin
            ctrl_err_d = 1'b1;
         end
         k_d       = 2'd0;
         x_d       = 16'd0;
         pix_cnt_d = 32'd0;
         if (pkt_type == PKT_CTRL) begin
            if (acc_eop) begin
               ctrl_err_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               state_d = S_CTRL;
            end
         end else if (pkt_type == PKT_VIDEO) begin
            if (acc_eop) begin
               frame_done_d  = 1'b1;
               frame_short_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               state_d = S_VIDEO;
            end
         end else begin
            state_d = acc_eop ? S_IDLE : S_OTHER;
         end
      end else if (acc_beat) begin
         case (state_q)
            S_CTRL: begin
               case (k_q)
                  2'd0: begin
                     shadow_d.width[15:4] = {nib0, nib1, nib2};
                     k_d = 2'd1;
                  end
                  2'd1: begin
                     shadow_d.width[3:0]   = nib0;
                     shadow_d.height[15:8] = {nib1, nib2};
                     k_d = 2'd2;
                  end
                  2'd2: begin
                     shadow_d.height[7:0] = {nib0, nib1};
                     shadow_d.interlace   = nib2;
                     k_d = 2'd3;
                  end
                  default: ;  // trailing beats carry nothing
               endcase
               if (acc_eop) begin
                  state_d = S_IDLE;
                  if (k_d == 2'd3 && shadow_d.width != 16'd0 &&
                      shadow_d.height != 16'd0) begin
                     fields_d      = shadow_d;
                     ctrl_update_d = 1'b1;
                  end else begin
                     ctrl_err_d = 1'b1;
                  end
               end
            end
            S_VIDEO: begin
               pix_sof   = (pix_cnt_q == 32'd0);
               pix_eol   = (x_q == fields_q.width - 16'd1);
               x_d       = pix_eol ? 16'd0 : x_q + 16'd1;
               pix_cnt_d = sat_inc32(pix_cnt_q);
               if (acc_eop) begin
                  frame_done_d  = 1'b1;
                  frame_short_d = (pix_cnt_d < frame_size);
                  frame_long_d  = (pix_cnt_d > frame_size);
                  state_d       = S_IDLE;
               end
            end
            S_OTHER: begin
               if (acc_eop) state_d = S_IDLE;
            end
            default: ;  // beats outside a packet are forwarded only
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q            <= S_IDLE;
         k_q                <= 2'd0;
         shadow_q           <= '0;
         fields_q.width     <= 16'(DEFAULT_WIDTH);
         fields_q.height    <= 16'(DEFAULT_HEIGHT);
         fields_q.interlace <= 4'h0;
         x_q                <= 16'd0;
         pix_cnt_q          <= 32'd0;
         ctrl_update_q      <= 1'b0;
         ctrl_err_q         <= 1'b0;
         frame_done_q       <= 1'b0;
         frame_short_q      <= 1'b0;
         frame_long_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         shadow_q      <= shadow_d;
         fields_q      <= fields_d;
         x_q           <= x_d;
         pix_cnt_q     <= pix_cnt_d;
         ctrl_update_q <= ctrl_update_d;
         ctrl_err_q    <= ctrl_err_d;
         frame_done_q  <= frame_done_d;
         frame_short_q <= frame_short_d;
         frame_long_q  <= frame_long_d;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: beat and its sideband travel together
   // ------------------------------------------------------------------
   logic [BW-1:0] skid_in, skid_out;
   logic          skid_valid;

   assign skid_in = {avst_din_sop_i, avst_din_eop_i, pix_eol, pix_sof, avst_din_data_i};

   avst_skid_buffer #(
      .DW (BW)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .in_valid_i  (avst_din_valid_i),
      .in_ready_o  (avst_din_ready_o),
      .in_data_i   (skid_in),
      .out_valid_o (skid_valid),
      .out_ready_i (avst_dout_ready_i),
      .out_data_o  (skid_out)
   );

   // Framing bits are masked when nothing is presented so stale flags never leak.
   assign avst_dout_valid_o = skid_valid;
   assign avst_dout_sop_o   = skid_valid & skid_out[BW-1];
   assign avst_dout_eop_o   = skid_valid & skid_out[BW-2];
   assign dout_eol_o        = skid_valid & skid_out[BW-3];
   assign dout_sof_o        = skid_valid & skid_out[BW-4];
   assign avst_dout_data_o  = skid_out[DW-1:0];

   assign width_o       = fields_q.width;
   assign height_o      = fields_q.height;
   assign interlace_o   = fields_q.interlace;
   assign ctrl_update_o = ctrl_update_q;
   assign ctrl_err_o    = ctrl_err_q;
   assign frame_done_o  = frame_done_q;
   assign frame_short_o = frame_short_q;
   assign frame_long_o  = frame_long_q;

endmodule

`default_nettype wire
